// File: rtl/updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter.
// Mode and direction encodings used by the counter datapath.
package updown_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/updown_counter_gen_prescaler.sv
// Enable prescaler: emits one step every prescale+1 enabled cycles.
// Ports: clk, rst_n, enable, clear (sync), prescale -> step.
module counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  step
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign step = enable & ~clear & (pre_cnt == prescale);

    // A prescale lowered below pre_cnt simply lets pre_cnt wrap
    // through its full range before it matches again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clear || step) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter_gen.sv
// Bounded up/down counter: wrap/saturate, load, prescaler, tc pulse.
// Ports: clk, rst_n, enable, up_down, sat_mode, max_value, prescale,
//        load, load_value -> count, tc (both registered).
module updown_counter_gen
    import updown_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      max_value,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      count,
    output logic                  tc
);

    logic             step;
    logic [WIDTH-1:0] nxt;
    logic             hit;
    logic [WIDTH-1:0] load_clamp;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (load),
        .prescale (prescale),
        .step     (step)
    );

    assign load_clamp = (load_value > max_value) ? max_value
                                                 : load_value;

    // Next value for a step; hit marks a step taken at the limit.
    always_comb begin
        nxt = count;
        hit = 1'b0;
        unique case (up_down)
            DIR_UP: begin
                if (count < max_value) begin
                    nxt = count + 1'b1;
                end else begin
                    hit = 1'b1;
                    nxt = (sat_mode == MODE_WRAP) ? '0 : max_value;
                end
            end
            DIR_DOWN: begin
                if (count == '0) begin
                    hit = 1'b1;
                    nxt = (sat_mode == MODE_SAT) ? '0 : max_value;
                end else if (count > max_value) begin
                    // limit lowered under a live count: snap to it
                    nxt = max_value;
                end else begin
                    nxt = count - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamp;
            tc    <= 1'b0;
        end else if (step) begin
            count <= nxt;
            tc    <= hit;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench for updown_counter_gen: directed + random
// stimulus against an arithmetic reference model.
module tb_updown_counter_gen;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          up_down;
    logic          sat_mode;
    logic [W-1:0]  max_value;
    logic [PW-1:0] prescale;
    logic          load;
    logic [W-1:0]  load_value;
    logic [W-1:0]  count;
    logic          tc;

    int checks   = 0;
    int failures = 0;

    int m_cnt = 0;
    int m_tc  = 0;
    int m_pre = 0;

    updown_counter_gen #(
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .up_down    (up_down),
        .sat_mode   (sat_mode),
        .max_value  (max_value),
        .prescale   (prescale),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic from the counting rules.
    always @(posedge clk or negedge rst_n) begin
        int mx;
        mx = int'(max_value);
        if (!rst_n) begin
            m_cnt = 0;
            m_tc  = 0;
            m_pre = 0;
        end else if (load) begin
            m_cnt = (int'(load_value) > mx) ? mx : int'(load_value);
            m_pre = 0;
            m_tc  = 0;
        end else if (enable && m_pre == int'(prescale)) begin
            m_pre = 0;
            m_tc  = 0;
            if (up_down) begin
                if (m_cnt < mx) m_cnt = m_cnt + 1;
                else begin
                    m_tc  = 1;
                    m_cnt = sat_mode ? mx : 0;
                end
            end else begin
                if (m_cnt == 0) begin
                    m_tc  = 1;
                    m_cnt = sat_mode ? 0 : mx;
                end else if (m_cnt > mx) m_cnt = mx;
                else m_cnt = m_cnt - 1;
            end
        end else begin
            if (enable) m_pre = (m_pre + 1) % (1 << PW);
            m_tc = 0;
        end
    end

    // Continuous compare on the falling edge, every cycle.
    always @(negedge clk) begin
        chk("model_count", int'(count), m_cnt);
        chk("model_tc", int'(tc), m_tc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v, input int mx);
        load       = 1'b1;
        load_value = W'(v);
        max_value  = W'(mx);
        tick();
        load       = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        up_down    = 1'b1;
        sat_mode   = 1'b0;
        max_value  = 8'd255;
        prescale   = '0;
        load       = 1'b0;
        load_value = '0;
        repeat (2) tick();
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);

        // full-range up count, wrap at 255
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (255) tick();
        chk("up255_count", int'(count), 255);
        chk("up255_tc", int'(tc), 0);
        tick();
        chk("wrap_count", int'(count), 0);
        chk("wrap_tc", int'(tc), 1);
        tick();
        chk("after_wrap_count", int'(count), 1);
        chk("after_wrap_tc", int'(tc), 0);

        // down wrap, max 9
        do_load(0, 9);
        up_down = 1'b0;
        tick();
        chk("down_wrap_count", int'(count), 9);
        chk("down_wrap_tc", int'(tc), 1);
        tick();
        chk("down8_count", int'(count), 8);
        chk("down8_tc", int'(tc), 0);
        tick();
        chk("down7_count", int'(count), 7);

        // saturate up at 5, then down at 0
        up_down  = 1'b1;
        sat_mode = 1'b1;
        do_load(3, 5);
        tick();
        chk("sat4", int'(count), 4);
        chk("sat4_tc", int'(tc), 0);
        tick();
        chk("sat5", int'(count), 5);
        chk("sat5_tc", int'(tc), 0);
        tick();
        chk("sat5b", int'(count), 5);
        chk("sat5b_tc", int'(tc), 1);
        tick();
        chk("sat5c_tc", int'(tc), 1);
        up_down = 1'b0;
        do_load(0, 5);
        tick();
        chk("sat0", int'(count), 0);
        chk("sat0_tc", int'(tc), 1);

        // prescale 3 with an enable gap
        sat_mode = 1'b0;
        up_down  = 1'b1;
        prescale = 4'd3;
        do_load(0, 255);
        repeat (3) tick();
        chk("pre_hold", int'(count), 0);
        tick();
        chk("pre_step", int'(count), 1);
        enable = 1'b0;
        repeat (2) tick();
        chk("pre_gap", int'(count), 1);
        enable = 1'b1;
        repeat (3) tick();
        chk("pre_resume_hold", int'(count), 1);
        tick();
        chk("pre_resume_step", int'(count), 2);

        // clamped load beats a simultaneous step
        prescale = '0;
        do_load(200, 100);
        chk("load_clamp", int'(count), 100);
        chk("load_tc", int'(tc), 0);
        tick();
        chk("post_load_wrap", int'(count), 0);
        chk("post_load_tc", int'(tc), 1);

        // limit lowered under the count
        do_load(50, 255);
        max_value = 8'd20;
        tick();
        chk("lower_up_wrap", int'(count), 0);
        sat_mode = 1'b1;
        do_load(50, 255);
        max_value = 8'd20;
        tick();
        chk("lower_up_sat", int'(count), 20);
        up_down = 1'b0;
        do_load(50, 255);
        max_value = 8'd20;
        tick();
        chk("lower_down", int'(count), 20);
        chk("lower_down_tc", int'(tc), 0);

        // async reset mid-count
        do_load(7, 255);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_tc", int'(tc), 0);
        tick();
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(3) != 0);
            load    = ($urandom_range(15) == 0);
            load_value = W'($urandom);
            if ($urandom_range(7) == 0) up_down = $urandom_range(1);
            if ($urandom_range(15) == 0) sat_mode = $urandom_range(1);
            if ($urandom_range(31) == 0)
                max_value = ($urandom_range(1) != 0)
                          ? W'($urandom_range(6))
                          : W'($urandom);
            if ($urandom_range(31) == 0)
                prescale = PW'($urandom_range(15) == 0
                               ? $urandom : $urandom_range(3));
            if ($urandom_range(499) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rand_rst_count", int'(count), 0);
                chk("rand_rst_tc", int'(tc), 0);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
